sni_host: RTL and testbench

- Initiator end of the SNI UART command protocol. It issues PING/READ/WRITE/WAITNMI transactions over the same UART byte interface that the console-side responder uses, and it parses the responses.
- A local client (debug/test logic on the host FPGA) presents one request at a time. The block serialises it, streams write payload in or read payload out, and reports completion status.
- It sits between the client logic and the UART core (strobe/txint/rxint/rdata_m style interface).

---
 rtl/sni_pkg.sv | 39 +++
 rtl/sni_rx_fifo.sv | 59 +++++
 rtl/sni_host.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sni_host.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sni_pkg.sv
// Shared definitions for the SNI UART command protocol.
// Used by the host-side initiator and intended for the console-side responder.
package sni_pkg;

  // Command byte values as they appear on the wire
  typedef enum logic [7:0] {
    CMD_PING    = 8'h00,
    CMD_READ    = 8'h01,
    CMD_WRITE   = 8'h02,
    CMD_WAITNMI = 8'h03
  } sni_cmd_e;

  // Completion status reported to the client with done
  typedef enum logic [1:0] {
    ST_OK            = 2'd0,
    ST_LEN_MISMATCH  = 2'd1,
    ST_ECHO_MISMATCH = 2'd2,
    ST_TIMEOUT       = 2'd3
  } sni_status_e;

  // Host transaction sequencer states
  typedef enum logic [3:0] {
    H_IDLE,
    H_TX_CMD,
    H_TX_A0,
    H_TX_A1,
    H_TX_A2,
    H_TX_LEN,
    H_TX_PING,
    H_RX_LEN,
    H_RX_DATA,
    H_TX_DATA,
    H_DONE
  } host_state_e;

  // Upper byte of every word handed to the UART transmitter
  localparam logic [7:0] SNI_TX_TAG = 8'h01;

endpackage

// File: rtl/sni_rx_fifo.sv
// Register-based RX byte FIFO between the UART receiver and the host sequencer.
// A push into a full FIFO is dropped; flush empties it in one cycle.
module sni_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = DEPTH[FIFO_AW:0];

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at 2^FIFO_AW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sni_host.sv
// SNI UART protocol initiator: serialises PING/READ/WRITE/WAITNMI requests
// onto the UART strobe interface and parses the responder's replies.
// Optional build macro SNI_HOST_TIMEOUT_EN adds a response timeout.
module sni_host
  import sni_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic        tdata_i,
  output logic [15:0] tdata_m,
  input  logic        txint,
  input  logic        rxint,
  input  logic [15:0] rdata_m,
  output logic        rbf
);

  host_state_e state;
  sni_cmd_e    cmd_r;
  sni_status_e status_r;
  logic [23:0] addr_r;
  logic [7:0]  len_r;
  logic [7:0]  exp_len;
  logic [7:0]  cnt;
  logic        tx_busy;
  logic        txint_p0;
  logic        rxint_p0;
  logic        tx_fall;
  logic        rx_fall;
  logic        rx_state;
  logic        to_hit;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_flush;
  logic [7:0]  fifo_dout;
  logic [7:0]  tx_byte;
  logic        tx_go;
  logic        unused_rdata_hi;

  // Only the low byte of a received word carries data
  assign unused_rdata_hi = ^rdata_m[15:8];

  // Stage p0: edge registers on the UART busy flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txint_p0 <= 1'b0;
      rxint_p0 <= 1'b0;
    end else begin
      txint_p0 <= txint;
      rxint_p0 <= rxint;
    end
  end

  assign tx_fall = txint_p0 & ~txint;
  assign rx_fall = rxint_p0 & ~rxint;

  sni_rx_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (fifo_flush),
    .push   (rx_fall),
    .din    (rdata_m[7:0]),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign rbf      = fifo_full;
  assign rx_state = (state == H_RX_LEN) || (state == H_RX_DATA);
  assign fifo_pop = rx_state && !fifo_empty && !to_hit;
  // Read payload is forwarded in the pop cycle only while the length matched
  assign rd_valid = (state == H_RX_DATA) && !fifo_empty && (cmd_r == CMD_READ)
                    && (status_r == ST_OK) && !to_hit;
  assign rd_data  = rd_valid ? fifo_dout : 8'h00;
  assign wr_ready = (state == H_TX_DATA) && !tx_busy && wr_valid && (cnt != 8'h00) && !to_hit;
  assign status   = status_r;

`ifdef SNI_HOST_TIMEOUT_EN
  logic [23:0] to_cnt;
  host_state_e state_p0;

  // Timeout counter: restarts on any state change or received byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt   <= '0;
      state_p0 <= H_IDLE;
    end else begin
      state_p0 <= state;
      if ((state != state_p0) || rx_fall) to_cnt <= '0;
      else if ((rx_state || tx_busy) && (to_cnt != TIMEOUT_CYC)) to_cnt <= to_cnt + 24'd1;
    end
  end

  assign to_hit     = (to_cnt == TIMEOUT_CYC) && (state != H_IDLE) && (state != H_DONE);
  assign fifo_flush = to_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to_hit         = 1'b0;
  assign fifo_flush     = 1'b0;
`endif

  // Byte selection for whichever TX state is active
  always_comb begin
    tx_byte = 8'h00;
    tx_go   = 1'b0;
    case (state)
      H_TX_CMD:  begin tx_byte = cmd_r;          tx_go = !tx_busy; end
      H_TX_A0:   begin tx_byte = addr_r[7:0];    tx_go = !tx_busy; end
      H_TX_A1:   begin tx_byte = addr_r[15:8];   tx_go = !tx_busy; end
      H_TX_A2:   begin tx_byte = addr_r[23:16];  tx_go = !tx_busy; end
      H_TX_LEN:  begin tx_byte = len_r;          tx_go = !tx_busy; end
      H_TX_PING: begin tx_byte = addr_r[7:0];    tx_go = !tx_busy; end
      H_TX_DATA: begin tx_byte = wr_data;        tx_go = wr_ready; end
      default:   begin tx_byte = 8'h00;          tx_go = 1'b0;     end
    endcase
  end

  // UART transmit strobe and busy tracking; busy ends on txint falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdata_i <= 1'b0;
      tdata_m <= 16'h0000;
      tx_busy <= 1'b0;
    end else if (to_hit) begin
      tdata_i <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      tdata_i <= tx_go;
      if (tx_go) begin
        tdata_m <= {SNI_TX_TAG, tx_byte};
        tx_busy <= 1'b1;
      end else if (tx_fall) begin
        tx_busy <= 1'b0;
      end
    end
  end

  // Transaction sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= H_IDLE;
      req_ready <= 1'b0;
      done      <= 1'b0;
      status_r  <= ST_OK;
      cmd_r     <= CMD_PING;
      addr_r    <= '0;
      len_r     <= '0;
      exp_len   <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (to_hit) begin
        status_r <= ST_TIMEOUT;
        done     <= 1'b1;
        state    <= H_DONE;
      end else begin
        case (state)
          H_IDLE: begin
            if (req_valid && req_ready) begin
              cmd_r     <= sni_cmd_e'({6'b000000, req_cmd});
              addr_r    <= req_addr;
              len_r     <= req_len;
              status_r  <= ST_OK;
              req_ready <= 1'b0;
              state     <= H_TX_CMD;
            end else begin
              req_ready <= 1'b1;
            end
          end
          H_TX_CMD: begin
            if (!tx_busy) begin
              case (cmd_r)
                CMD_PING:            state <= H_TX_PING;
                CMD_READ, CMD_WRITE: state <= H_TX_A0;
                default: begin
                  exp_len <= 8'h00;
                  state   <= H_RX_LEN;
                end
              endcase
            end
          end
          H_TX_A0: if (!tx_busy) state <= H_TX_A1;
          H_TX_A1: if (!tx_busy) state <= H_TX_A2;
          H_TX_A2: if (!tx_busy) state <= H_TX_LEN;
          H_TX_LEN: begin
            if (!tx_busy) begin
              exp_len <= (cmd_r == CMD_READ) ? len_r : 8'h00;
              state   <= H_RX_LEN;
            end
          end
          H_TX_PING: begin
            if (!tx_busy) begin
              exp_len <= 8'h01;
              state   <= H_RX_LEN;
            end
          end
          H_RX_LEN: begin
            if (!fifo_empty) begin
              if (fifo_dout != exp_len) status_r <= ST_LEN_MISMATCH;
              cnt <= fifo_dout;
              if (fifo_dout == 8'h00) begin
                // A zero-length reply to WRITE is the go-ahead for the payload
                if ((cmd_r == CMD_WRITE) && (len_r != 8'h00)) begin
                  cnt   <= len_r;
                  state <= H_TX_DATA;
                end else begin
                  done  <= 1'b1;
                  state <= H_DONE;
                end
              end else begin
                state <= H_RX_DATA;
              end
            end
          end
          H_RX_DATA: begin
            if (!fifo_empty) begin
              if ((cmd_r == CMD_PING) && (status_r == ST_OK) && (fifo_dout != addr_r[7:0]))
                status_r <= ST_ECHO_MISMATCH;
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) begin
                done  <= 1'b1;
                state <= H_DONE;
              end
            end
          end
          H_TX_DATA: begin
            // After the last byte, finish once the UART reports it sent
            if (cnt == 8'h00) begin
              if (!tx_busy || tx_fall) begin
                done  <= 1'b1;
                state <= H_DONE;
              end
            end else if (wr_ready) begin
              cnt <= cnt - 8'd1;
            end
          end
          H_DONE: begin
            req_ready <= 1'b1;
            state     <= H_IDLE;
          end
          default: state <= H_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sni_host.sv
// Directed scoreboard bench for sni_host: expected TX words and read bytes are
// queued when a request is issued and checked as the DUT produces them.
module tb_sni_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic [1:0]  status;
  logic        tdata_i;
  logic [15:0] tdata_m;
  logic        txint;
  logic        rxint;
  logic [15:0] rdata_m;
  logic        rbf;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_tx[$];
  logic [7:0]  exp_rd[$];
  int          done_cnt = 0;
  logic [1:0]  done_status = 2'd0;
  int          wr_seen = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          done_cyc = 0;

  always #5 clk = ~clk;

  sni_host #(.FIFO_AW(4), .TIMEOUT_CYC(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .status(status), .tdata_i(tdata_i), .tdata_m(tdata_m), .txint(txint),
    .rxint(rxint), .rdata_m(rdata_m), .rbf(rbf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: compare strobes and read bytes, record done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (tdata_i) begin
        strobe_cyc = cyc;
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tdata_m), 32'hFFFF_FFFF);
        else chk("tx_word", 32'(tdata_m), 32'(exp_tx.pop_front()));
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        else chk("rd_byte", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      if (wr_ready) wr_seen++;
      if (done) begin
        done_cnt++;
        done_status = status;
        done_cyc    = cyc;
      end
    end
  end

  // UART transmitter model: busy for three cycles after each strobe
  initial begin
    int tx_timer;
    tx_timer = 0;
    txint = 1'b0;
    forever begin
      @(negedge clk);
      if (tdata_i) begin
        txint    = 1'b1;
        tx_timer = 3;
      end else if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0) txint = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_wr_ready"},  32'(wr_ready),  0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  0);
    chk({tag, "_rd_data"},   32'(rd_data),   0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_status"},    32'(status),    0);
    chk({tag, "_tdata_i"},   32'(tdata_i),   0);
    chk({tag, "_tdata_m"},   32'(tdata_m),   0);
    chk({tag, "_rbf"},       32'(rbf),       0);
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [23:0] addr, input logic [7:0] len);
    int c = 0;
    while (!req_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_cmd   = cmd;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rdata_m = {8'h5A, b};
    rxint   = 1'b1;
    @(negedge clk);
    rxint   = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_payload(input logic [7:0] b0, input logic [7:0] b1);
    int idx = 0;
    wr_data  = b0;
    wr_valid = 1'b1;
    for (int c = 0; c < 500 && idx < 2; c++) begin
      @(negedge clk);
      if (wr_ready) begin
        idx++;
        @(posedge clk);
        #1;
        if (idx < 2) wr_data = b1;
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev, input logic [1:0] exp_status);
    int c = 0;
    while (done_cnt == prev && c < 3000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'(prev + 1));
    chk({tag, "_status"}, 32'(done_status), 32'(exp_status));
    chk({tag, "_tx_left"}, 32'(exp_tx.size()), 0);
    chk({tag, "_rd_left"}, 32'(exp_rd.size()), 0);
  endtask

  initial begin
    int d0;
    int w0;
    int c;
    req_valid = 1'b0;
    req_cmd   = 2'd0;
    req_addr  = 24'h0;
    req_len   = 8'h0;
    wr_data   = 8'h0;
    wr_valid  = 1'b0;
    rxint     = 1'b0;
    rdata_m   = 16'h0;

    // Power-on reset
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("por_ready_before_clk", 32'(req_ready), 0);
    @(negedge clk);
    chk("por_ready_after_clk", 32'(req_ready), 1);

    // PING A5
    d0 = done_cnt;
    exp_tx.push_back(16'h0100); exp_tx.push_back(16'h01A5);
    issue(2'd0, 24'h0000A5, 8'h00);
    rx_byte(8'h01); rx_byte(8'hA5);
    wait_done("ping", d0, 2'd0);

    // READ 7E1234 len 3
    d0 = done_cnt;
    exp_tx.push_back(16'h0101); exp_tx.push_back(16'h0134); exp_tx.push_back(16'h0112);
    exp_tx.push_back(16'h017E); exp_tx.push_back(16'h0103);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    issue(2'd1, 24'h7E1234, 8'd3);
    rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    wait_done("read", d0, 2'd0);

    // WRITE F50010 len 2
    d0 = done_cnt;
    w0 = wr_seen;
    exp_tx.push_back(16'h0102); exp_tx.push_back(16'h0110); exp_tx.push_back(16'h0100);
    exp_tx.push_back(16'h01F5); exp_tx.push_back(16'h0102);
    exp_tx.push_back(16'h01DE); exp_tx.push_back(16'h01AD);
    issue(2'd2, 24'hF50010, 8'd2);
    rx_byte(8'h00);
    send_payload(8'hDE, 8'hAD);
    wait_done("write", d0, 2'd0);
    chk("write_wr_ready_count", 32'(wr_seen - w0), 2);

    // READ len 2 answered with length 1: payload discarded
    d0 = done_cnt;
    exp_tx.push_back(16'h0101); exp_tx.push_back(16'h0156); exp_tx.push_back(16'h0134);
    exp_tx.push_back(16'h0112); exp_tx.push_back(16'h0102);
    issue(2'd1, 24'h123456, 8'd2);
    rx_byte(8'h01); rx_byte(8'h55);
    wait_done("read_lenmis", d0, 2'd1);
    chk("read_lenmis_fifo_empty_rbf", 32'(rbf), 0);

    // WAITNMI answered with zero length
    d0 = done_cnt;
    exp_tx.push_back(16'h0103);
    issue(2'd3, 24'h000000, 8'd0);
    rx_byte(8'h00);
    wait_done("waitnmi", d0, 2'd0);

    // PING with a wrong echo byte
    d0 = done_cnt;
    exp_tx.push_back(16'h0100); exp_tx.push_back(16'h0177);
    issue(2'd0, 24'h000077, 8'h00);
    rx_byte(8'h01); rx_byte(8'h78);
    wait_done("ping_echo", d0, 2'd2);

    // Fill the RX FIFO while idle: 16 fit, the 17th is dropped
    for (int i = 0; i < 16; i++) begin
      rx_byte((i == 0) ? 8'h0F : 8'(8'h80 + i - 1));
      if (i == 14) chk("fifo_15_rbf", 32'(rbf), 0);
    end
    chk("fifo_16_rbf", 32'(rbf), 1);
    rx_byte(8'hEE);
    chk("fifo_17_rbf", 32'(rbf), 1);
    d0 = done_cnt;
    exp_tx.push_back(16'h0101); exp_tx.push_back(16'h01CD); exp_tx.push_back(16'h01AB);
    exp_tx.push_back(16'h0100); exp_tx.push_back(16'h010F);
    for (int i = 0; i < 15; i++) exp_rd.push_back(8'(8'h80 + i));
    issue(2'd1, 24'h00ABCD, 8'd15);
    wait_done("fifo_drain", d0, 2'd0);
    chk("fifo_drain_rbf", 32'(rbf), 0);

    // Reset in the middle of a READ
    exp_tx.push_back(16'h0101); exp_tx.push_back(16'h0166); exp_tx.push_back(16'h0155);
    exp_tx.push_back(16'h0144); exp_tx.push_back(16'h0103);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    issue(2'd1, 24'h445566, 8'd3);
    c = 0;
    while (exp_tx.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_tx_sent", 32'(exp_tx.size()), 0);
    rx_byte(8'h03); rx_byte(8'h11); rx_byte(8'h22);
    repeat (2) @(negedge clk);
    chk("midrst_rd_seen", 32'(exp_rd.size()), 0);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("midrst_ready_before_clk", 32'(req_ready), 0);
    @(negedge clk);
    chk("midrst_ready_after_clk", 32'(req_ready), 1);
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));

    // Normal operation after the abandoned transaction
    d0 = done_cnt;
    exp_tx.push_back(16'h0100); exp_tx.push_back(16'h013C);
    issue(2'd0, 24'h00003C, 8'h00);
    rx_byte(8'h01); rx_byte(8'h3C);
    wait_done("ping_after_rst", d0, 2'd0);

`ifdef SNI_HOST_TIMEOUT_EN
    // WAITNMI with no reply times out about TIMEOUT_CYC after the command byte
    d0 = done_cnt;
    exp_tx.push_back(16'h0103);
    issue(2'd3, 24'h000000, 8'd0);
    wait_done("timeout", d0, 2'd3);
    chk("timeout_latency_window",
        32'(((done_cyc - strobe_cyc) >= 98) && ((done_cyc - strobe_cyc) <= 106)), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
